// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: direction and boundary-mode values.
package counter_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter; master drives controls, slave returns count state.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_max;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, sat, load, load_val, mod_max, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, up_dn, sat, load, load_val, mod_max, clr_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/mod_updown_counter_step.sv
// Combinational next-value and terminal-event detection for one enabled counter step.
module count_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] next,
  output logic             term
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    next = count;
    term = 1'b0;
    if (count > mod_max) begin
      // Out of range after a limit change: snap back into range, never terminal.
      next = (up_dn == DIR_UP && sat == MODE_WRAP) ? '0 : mod_max;
    end else if (up_dn == DIR_UP) begin
      if (count == mod_max) begin
        term = 1'b1;
        next = (sat == MODE_SAT) ? mod_max : '0;
      end else begin
        next = count + ONE;
      end
    end else if (up_dn == DIR_DOWN) begin
      if (count == '0) begin
        term = 1'b1;
        next = (sat == MODE_SAT) ? '0 : mod_max;
      end else begin
        next = count - ONE;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, wrap/saturate mode, terminal-count pulse and sticky overflow.
// Fully registered outputs; priority is rst > load > en > hold.
module mod_updown_counter #(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_next;
  logic             step_term;

  count_step #(.WIDTH(WIDTH)) u_step (
    .count   (count_q),
    .up_dn   (up_dn),
    .sat     (sat),
    .mod_max (mod_max),
    .next    (step_next),
    .term    (step_term)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = (load_val > mod_max) ? mod_max : load_val;
    end else if (en) begin
      count_d = step_next;
      if (step_term) begin
        // Setting the sticky flag outranks a same-cycle clear.
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_COUNT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed bench for mod_updown_counter against an integer reference model.
module tb_mod_updown_counter;
  localparam int WIDTH = 4;
  localparam int RV    = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  mod_updown_counter #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .up_dn    (bus.up_dn),
    .sat      (bus.sat),
    .load     (bus.load),
    .load_val (bus.load_val),
    .mod_max  (bus.mod_max),
    .clr_ovf  (bus.clr_ovf),
    .count    (bus.count),
    .tc       (bus.tc),
    .ovf      (bus.ovf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic straight from the counting rules.
  int m_count = RV;
  int m_tc    = 0;
  int m_ovf   = 0;

  always @(posedge clk) begin
    int c, mm, lv;
    bit up, s, term, stepped;
    c = m_count; mm = int'(bus.mod_max); lv = int'(bus.load_val);
    up = bus.up_dn; s = bus.sat; term = 0;
    stepped = !rst && (bus.load || bus.en);
    if (rst) begin
      m_count = RV; m_tc = 0; m_ovf = 0;
    end else if (bus.load) begin
      m_count = (lv < mm) ? lv : mm;
      m_tc = 0;
      m_ovf = (m_ovf != 0 && !bus.clr_ovf) ? 1 : 0;
    end else if (bus.en) begin
      if (c > mm)       m_count = (up && !s) ? 0 : mm;
      else if (up) begin
        term = (c == mm);
        m_count = term ? (s ? mm : 0) : c + 1;
      end else begin
        term = (c == 0);
        m_count = term ? (s ? 0 : mm) : c - 1;
      end
      m_tc = term;
      m_ovf = (term || (m_ovf != 0 && !bus.clr_ovf)) ? 1 : 0;
    end else begin
      m_tc = 0;
      m_ovf = (m_ovf != 0 && !bus.clr_ovf) ? 1 : 0;
    end
    #1;
    chk("model_count", int'(bus.count), m_count);
    chk("model_tc", int'(bus.tc), m_tc);
    chk("model_ovf", int'(bus.ovf), m_ovf);
    if (stepped) chk("count_in_range", (int'(bus.count) <= mm) ? 1 : 0, 1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.en = 0; bus.up_dn = 1; bus.sat = 0; bus.load = 0;
    bus.load_val = '0; bus.mod_max = 4'd15; bus.clr_ovf = 0;
    rst = 1;
    tick(); tick();
    chk("reset_count", int'(bus.count), RV);
    chk("reset_tc", int'(bus.tc), 0);
    chk("reset_ovf", int'(bus.ovf), 0);

    // Full up-count wrap at mod_max=15.
    rst = 0; bus.en = 1; bus.up_dn = 1; bus.sat = 0; bus.mod_max = 4'd15;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("up_wrap_count", int'(bus.count), k % 16);
      chk("up_wrap_tc", int'(bus.tc), (k == 16) ? 1 : 0);
    end
    tick();
    chk("after_wrap_count", int'(bus.count), 1);
    chk("after_wrap_tc", int'(bus.tc), 0);
    chk("after_wrap_ovf", int'(bus.ovf), 1);

    // Down wrap from 0 to mod_max=9.
    rst = 1; tick(); rst = 0;
    bus.up_dn = 0; bus.mod_max = 4'd9;
    tick();
    chk("down_wrap_count", int'(bus.count), 9);
    chk("down_wrap_tc", int'(bus.tc), 1);
    tick();
    chk("down_8", int'(bus.count), 8);
    chk("down_8_tc", int'(bus.tc), 0);
    tick();
    chk("down_7", int'(bus.count), 7);

    // Saturation at mod_max=5 held for three cycles.
    bus.load = 1; bus.load_val = 4'd5; bus.mod_max = 4'd5; bus.up_dn = 1;
    tick();
    chk("load5_tc", int'(bus.tc), 0);
    bus.load = 0; bus.sat = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_hold_count", int'(bus.count), 5);
      chk("sat_hold_tc", int'(bus.tc), 1);
    end

    // Load clamps to mod_max; reset beats load.
    bus.sat = 0; bus.load = 1; bus.load_val = 4'd12; bus.mod_max = 4'd7;
    tick();
    chk("load_clamp_count", int'(bus.count), 7);
    chk("load_clamp_tc", int'(bus.tc), 0);
    rst = 1;
    tick();
    chk("rst_over_load", int'(bus.count), RV);
    chk("rst_over_load_ovf", int'(bus.ovf), 0);
    rst = 0;

    // Out-of-range count after mod_max shrinks.
    bus.mod_max = 4'd15; bus.load_val = 4'd10;
    tick();
    chk("load10", int'(bus.count), 10);
    bus.load = 0; bus.mod_max = 4'd6; bus.up_dn = 0; bus.en = 1;
    tick();
    chk("oor_down_count", int'(bus.count), 6);
    chk("oor_down_tc", int'(bus.tc), 0);

    // Set beats clear, hold keeps ovf, clear alone drops it.
    bus.load = 1; bus.load_val = 4'd0;
    tick();
    bus.load = 0; bus.sat = 1; bus.clr_ovf = 1;
    tick();
    chk("set_over_clr_ovf", int'(bus.ovf), 1);
    chk("sat_down_tc", int'(bus.tc), 1);
    bus.en = 0; bus.clr_ovf = 0;
    tick();
    chk("hold_tc", int'(bus.tc), 0);
    chk("hold_ovf", int'(bus.ovf), 1);
    bus.clr_ovf = 1;
    tick();
    chk("clr_ovf", int'(bus.ovf), 0);
    bus.clr_ovf = 0;

    // mod_max=0: every step is terminal.
    bus.mod_max = 4'd0; bus.en = 1; bus.sat = 0; bus.up_dn = 1;
    tick();
    chk("mm0_up_count", int'(bus.count), 0);
    chk("mm0_up_tc", int'(bus.tc), 1);
    bus.up_dn = 0;
    tick();
    chk("mm0_dn_tc", int'(bus.tc), 1);

    for (int i = 0; i < 10000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.up_dn    = 1'($urandom);
      bus.sat      = 1'($urandom);
      bus.clr_ovf  = ($urandom_range(0, 15) == 0);
      bus.load_val = WIDTH'($urandom);
      if ($urandom_range(0, 19) == 0) bus.mod_max = WIDTH'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
